// File: rtl/img_sequencer_pkg.sv
// ============================================================================
// Module  : img_sequencer_pkg
// Brief   : Shared state encoding, error codes and helpers for img_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package img_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAP_ISSUE = 3'd1,
        ST_CAP_WAIT  = 3'd2,
        ST_CAP_CHECK = 3'd3,
        ST_RD_ISSUE  = 3'd4,
        ST_RD_WAIT   = 3'd5
    } state_t;

    localparam logic [1:0] c_ERR_OK          = 2'd0;
    localparam logic [1:0] c_ERR_TIMEOUT     = 2'd1;
    localparam logic [1:0] c_ERR_SHORT_FRAME = 2'd2;
    localparam logic [1:0] c_ERR_NO_IMAGE    = 2'd3;

    // Number of bits needed to hold the value v (at least 1).
    function automatic int unsigned reg_width(input longint unsigned v);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 64; i++) begin
            if ((v >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // A toggle-style handshake has fired when it differs from its reference.
    function automatic logic toggle_pulse(input logic i_cur, input logic i_ref);
        return i_cur ^ i_ref;
    endfunction

endpackage

`default_nettype wire

// File: rtl/img_sequencer_timer.sv
// ============================================================================
// Module  : img_seq_timer
// Brief   : Loadable down-counter with a zero flag for the capture timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module img_seq_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/img_sequencer.sv
// ============================================================================
// Module  : img_sequencer
// Brief   : Double-buffered capture/readout sequencer for the image controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module img_sequencer
    import img_sequencer_pkg::*;
#(
    parameter int unsigned  CLK_FREQ           = 24_000_000,
    parameter int unsigned  IMG_PIXEL_COUNT    = 4096 * 4096,
    parameter int unsigned  CAPTURE_TIMEOUT_MS = 1000,
    localparam int unsigned c_PIX_W            = reg_width(longint'(IMG_PIXEL_COUNT))
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               host_capture,
    input  logic               host_captureSkip,
    input  logic               host_readout,
    input  logic               host_readoutThumb,
    input  logic               host_readoutDone,
    output logic               status_busy,
    output logic               status_done,
    output logic [1:0]         status_err,
    output logic [1:0]         status_validBlocks,
    output logic               img_cmd_capture,
    output logic               img_cmd_readout,
    output logic               img_cmd_ramBlock,
    output logic               img_cmd_skipCount,
    output logic               img_cmd_thumb,
    input  logic               img_status_captureDone,
    input  logic [c_PIX_W-1:0] img_status_pixelCount
);

    localparam longint unsigned c_TMR_CYCLES =
        longint'(CAPTURE_TIMEOUT_MS) * longint'(CLK_FREQ / 1000);
    localparam int unsigned      c_TMR_W    = reg_width(c_TMR_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LOAD = c_TMR_W'(c_TMR_CYCLES - 1);
    localparam logic [c_PIX_W-1:0] c_PIX_EXP  = c_PIX_W'(IMG_PIXEL_COUNT);

    state_t     r_state, w_state_nxt;
    logic       r_cap_pend, r_rd_pend;
    logic       r_skip, r_thumb;
    logic       r_latest, w_latest_nxt;
    logic       r_target, w_target_nxt;
    logic       r_done_ref, w_done_ref_nxt;
    logic [1:0] r_valid, w_valid_nxt;
    logic [1:0] r_err, w_err_nxt;
    logic       r_done, w_done_nxt;
    logic       r_cmd_cap, w_cmd_cap_nxt;
    logic       r_cmd_rd, w_cmd_rd_nxt;
    logic       r_ram_blk, w_ram_blk_nxt;
    logic       r_cmd_skip, w_cmd_skip_nxt;
    logic       r_cmd_thumb, w_cmd_thumb_nxt;
    logic       w_cap_issue, w_rd_issue;
    logic       w_tmr_load, w_tmr_dec, w_tmr_zero;
    logic       w_cap_req, w_rd_req;

    // Idle also looks at this cycle's pulse so a request issues one edge sooner.
    assign w_cap_req = r_cap_pend | host_capture;
    assign w_rd_req  = r_rd_pend  | host_readout;

    img_seq_timer #(
        .WIDTH (c_TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (c_TMR_LOAD),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // A new pulse wins over the clear so a request arriving at issue is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_pend <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_skip     <= 1'b0;
            r_thumb    <= 1'b0;
        end else begin
            if (host_capture) begin
                r_cap_pend <= 1'b1;
                r_skip     <= host_captureSkip;
            end else if (w_cap_issue) begin
                r_cap_pend <= 1'b0;
            end
            if (host_readout) begin
                r_rd_pend <= 1'b1;
                r_thumb   <= host_readoutThumb;
            end else if (w_rd_issue) begin
                r_rd_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_latest    <= 1'b0;
            r_target    <= 1'b0;
            r_done_ref  <= 1'b0;
            r_valid     <= 2'b00;
            r_err       <= c_ERR_OK;
            r_done      <= 1'b0;
            r_cmd_cap   <= 1'b0;
            r_cmd_rd    <= 1'b0;
            r_ram_blk   <= 1'b0;
            r_cmd_skip  <= 1'b0;
            r_cmd_thumb <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_latest    <= w_latest_nxt;
            r_target    <= w_target_nxt;
            r_done_ref  <= w_done_ref_nxt;
            r_valid     <= w_valid_nxt;
            r_err       <= w_err_nxt;
            r_done      <= w_done_nxt;
            r_cmd_cap   <= w_cmd_cap_nxt;
            r_cmd_rd    <= w_cmd_rd_nxt;
            r_ram_blk   <= w_ram_blk_nxt;
            r_cmd_skip  <= w_cmd_skip_nxt;
            r_cmd_thumb <= w_cmd_thumb_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_latest_nxt    = r_latest;
        w_target_nxt    = r_target;
        w_done_ref_nxt  = r_done_ref;
        w_valid_nxt     = r_valid;
        w_err_nxt       = r_err;
        w_done_nxt      = 1'b0;
        w_cmd_cap_nxt   = r_cmd_cap;
        w_cmd_rd_nxt    = r_cmd_rd;
        w_ram_blk_nxt   = r_ram_blk;
        w_cmd_skip_nxt  = r_cmd_skip;
        w_cmd_thumb_nxt = r_cmd_thumb;
        w_cap_issue     = 1'b0;
        w_rd_issue      = 1'b0;
        w_tmr_load      = 1'b0;
        w_tmr_dec       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Readout first: a later capture never overwrites the block it reads.
                if (w_rd_req) begin
                    w_state_nxt = ST_RD_ISSUE;
                end else if (w_cap_req) begin
                    w_state_nxt = ST_CAP_ISSUE;
                end
            end
            ST_CAP_ISSUE: begin
                w_cap_issue           = 1'b1;
                w_target_nxt          = ~r_latest;
                w_valid_nxt[~r_latest] = 1'b0;
                w_ram_blk_nxt         = ~r_latest;
                w_cmd_cap_nxt         = ~r_cmd_cap;
                w_cmd_skip_nxt        = r_skip;
                w_done_ref_nxt        = img_status_captureDone;
                w_tmr_load            = 1'b1;
                w_state_nxt           = ST_CAP_WAIT;
            end
            ST_CAP_WAIT: begin
                if (toggle_pulse(img_status_captureDone, r_done_ref)) begin
                    w_state_nxt = ST_CAP_CHECK;
                end else if (w_tmr_zero) begin
                    w_err_nxt   = c_ERR_TIMEOUT;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_CAP_CHECK: begin
                if (img_status_pixelCount == c_PIX_EXP) begin
                    w_err_nxt             = c_ERR_OK;
                    w_valid_nxt[r_target] = 1'b1;
                    w_latest_nxt          = r_target;
                end else begin
                    w_err_nxt = c_ERR_SHORT_FRAME;
                end
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                w_rd_issue = 1'b1;
                if (!r_valid[r_latest]) begin
                    w_err_nxt   = c_ERR_NO_IMAGE;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_ram_blk_nxt   = r_latest;
                    w_cmd_rd_nxt    = ~r_cmd_rd;
                    w_cmd_thumb_nxt = r_thumb;
                    w_state_nxt     = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (host_readoutDone) begin
                    w_err_nxt   = c_ERR_OK;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign status_busy        = (r_state != ST_IDLE);
    assign status_done        = r_done;
    assign status_err         = r_err;
    assign status_validBlocks = r_valid;
    assign img_cmd_capture    = r_cmd_cap;
    assign img_cmd_readout    = r_cmd_rd;
    assign img_cmd_ramBlock   = r_ram_blk;
    assign img_cmd_skipCount  = r_cmd_skip;
    assign img_cmd_thumb      = r_cmd_thumb;

endmodule

`default_nettype wire

// File: tb/tb_img_sequencer.sv
// ============================================================================
// Module  : tb_img_sequencer
// Brief   : Self-checking bench for img_sequencer against a transaction model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_img_sequencer;

    localparam int unsigned c_CLK_FREQ = 1_000_000;
    localparam int unsigned c_PIX      = 64;
    localparam int unsigned c_TMO_MS   = 1;
    localparam int          c_PW       = 7;
    localparam int          c_TMO_CYC  = c_TMO_MS * (c_CLK_FREQ / 1000);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic host_capture = 1'b0, host_captureSkip = 1'b0;
    logic host_readout = 1'b0, host_readoutThumb = 1'b0, host_readoutDone = 1'b0;
    logic img_status_captureDone = 1'b0;
    logic [c_PW-1:0] img_status_pixelCount = '0;
    logic status_busy, status_done;
    logic [1:0] status_err, status_validBlocks;
    logic img_cmd_capture, img_cmd_readout, img_cmd_ramBlock, img_cmd_skipCount, img_cmd_thumb;

    always #5 clk = ~clk;

    img_sequencer #(
        .CLK_FREQ           (c_CLK_FREQ),
        .IMG_PIXEL_COUNT    (c_PIX),
        .CAPTURE_TIMEOUT_MS (c_TMO_MS)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .host_capture           (host_capture),
        .host_captureSkip       (host_captureSkip),
        .host_readout           (host_readout),
        .host_readoutThumb      (host_readoutThumb),
        .host_readoutDone       (host_readoutDone),
        .status_busy            (status_busy),
        .status_done            (status_done),
        .status_err             (status_err),
        .status_validBlocks     (status_validBlocks),
        .img_cmd_capture        (img_cmd_capture),
        .img_cmd_readout        (img_cmd_readout),
        .img_cmd_ramBlock       (img_cmd_ramBlock),
        .img_cmd_skipCount      (img_cmd_skipCount),
        .img_cmd_thumb          (img_cmd_thumb),
        .img_status_captureDone (img_status_captureDone),
        .img_status_pixelCount  (img_status_pixelCount)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: which blocks hold good images, the newest one, last result.
    logic [1:0] m_valid;
    logic       m_latest;
    logic [1:0] m_err;
    logic       m_cap_t, m_rd_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 2'b00; m_latest = 1'b0; m_err = 2'd0; m_cap_t = 1'b0; m_rd_t = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  status_busy, 0);
        check({tag, "_done"},  status_done, 0);
        check({tag, "_err"},   status_err, 0);
        check({tag, "_valid"}, status_validBlocks, 0);
        check({tag, "_ctgl"},  img_cmd_capture, 0);
        check({tag, "_rtgl"},  img_cmd_readout, 0);
        check({tag, "_blk"},   img_cmd_ramBlock, 0);
        check({tag, "_skip"},  img_cmd_skipCount, 0);
        check({tag, "_thumb"}, img_cmd_thumb, 0);
    endtask

    // mode 0: good frame, 1: short frame, 2: no captureDone (timeout)
    task automatic cap_body(input logic tgt, input logic skip, input int mode, input int dly);
        int cyc;
        check("cap_block", img_cmd_ramBlock, tgt);
        check("cap_skip", img_cmd_skipCount, skip);
        check("cap_valid_clr", status_validBlocks, m_valid);
        check("cap_busy", status_busy, 1);
        if (mode == 2) begin
            cyc = 0;
            while (!status_done && cyc < c_TMO_CYC + 100) begin
                @(negedge clk);
                cyc++;
            end
            check("tmo_cycles", cyc, c_TMO_CYC);
            m_err = 2'd1;
        end else begin
            repeat (dly) @(negedge clk);
            check("cap_no_early_done", status_done, 0);
            img_status_pixelCount = (mode == 0) ? c_PW'(c_PIX) : c_PW'(c_PIX - 1);
            img_status_captureDone = ~img_status_captureDone;
            @(negedge clk);
            check("cap_done_lat", status_done, 0);
            @(negedge clk);
            if (mode == 0) begin
                m_err = 2'd0; m_valid[tgt] = 1'b1; m_latest = tgt;
            end else begin
                m_err = 2'd2;
            end
        end
        check("cap_done", status_done, 1);
        check("cap_err", status_err, m_err);
        check("cap_valid", status_validBlocks, m_valid);
        @(negedge clk);
        check("cap_done_pulse", status_done, 0);
        check("cap_idle", status_busy, 0);
    endtask

    task automatic capture(input logic skip, input int mode, input int dly);
        logic tgt;
        tgt = ~m_latest;
        @(negedge clk);
        host_capture = 1'b1; host_captureSkip = skip;
        @(negedge clk);
        host_capture = 1'b0; host_captureSkip = 1'($urandom_range(0, 1));
        check("cap_early", img_cmd_capture, m_cap_t);
        m_cap_t = ~m_cap_t;
        m_valid[tgt] = 1'b0;
        @(negedge clk);
        check("cap_toggle", img_cmd_capture, m_cap_t);
        cap_body(tgt, skip, mode, dly);
    endtask

    // with_cap: also pulse a capture in the same cycle (readout must go first)
    task automatic readout(input logic thumb, input int hold, input logic with_cap, input logic cskip);
        logic tgt;
        int   k;
        @(negedge clk);
        host_readout = 1'b1; host_readoutThumb = thumb;
        if (with_cap) begin
            host_capture = 1'b1; host_captureSkip = cskip;
        end
        @(negedge clk);
        host_readout = 1'b0; host_capture = 1'b0;
        check("rd_early", img_cmd_readout, m_rd_t);
        @(negedge clk);
        check("rd_cap_held", img_cmd_capture, m_cap_t);
        if (!m_valid[m_latest]) begin
            m_err = 2'd3;
            check("rd_noimg_done", status_done, 1);
            check("rd_noimg_err", status_err, m_err);
            check("rd_no_toggle", img_cmd_readout, m_rd_t);
        end else begin
            m_rd_t = ~m_rd_t;
            check("rd_toggle", img_cmd_readout, m_rd_t);
            check("rd_block", img_cmd_ramBlock, m_latest);
            check("rd_thumb", img_cmd_thumb, thumb);
            repeat (hold) @(negedge clk);
            check("rd_wait_busy", status_busy, 1);
            check("rd_wait_nodone", status_done, 0);
            host_readoutDone = 1'b1;
            @(negedge clk);
            host_readoutDone = 1'b0;
            m_err = 2'd0;
            check("rd_done", status_done, 1);
            check("rd_err", status_err, m_err);
        end
        @(negedge clk);
        check("rd_done_pulse", status_done, 0);
        check("rd_busy_after", status_busy, with_cap);
        if (with_cap) begin
            tgt = ~m_latest;
            k = 0;
            while (img_cmd_capture === m_cap_t && k < 8) begin
                @(negedge clk);
                k++;
            end
            m_cap_t = ~m_cap_t;
            m_valid[tgt] = 1'b0;
            check("rc_cap_toggle", img_cmd_capture, m_cap_t);
            cap_body(tgt, cskip, 0, 5);
        end
    endtask

    initial begin : main
        int nd;
        int op;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Readout with nothing captured
        readout(1'b0, 0, 1'b0, 1'b0);
        check("noimg_valid", status_validBlocks, 2'b00);

        // First capture lands in block 1, second in block 0
        capture(1'b1, 0, 100);
        check("first_valid", status_validBlocks, 2'b10);
        capture(1'b0, 0, 20);
        check("second_valid", status_validBlocks, 2'b11);
        readout(1'b1, 3, 1'b0, 1'b0);

        // Short frame leaves the target invalid and latest unchanged
        capture(1'b1, 1, 7);
        check("short_valid", status_validBlocks, 2'b01);
        readout(1'b0, 2, 1'b0, 1'b0);

        // Timeout, then a late captureDone while idle is ignored
        capture(1'b0, 2, 0);
        img_status_captureDone = ~img_status_captureDone;
        nd = 0;
        repeat (5) begin
            @(negedge clk);
            if (status_done) nd++;
        end
        check("late_toggle_done", nd, 0);
        check("late_toggle_busy", status_busy, 0);
        capture(1'b1, 0, 4);

        // Simultaneous requests with an image available
        readout(1'b1, 4, 1'b1, 1'b1);

        // Stray readoutDone outside a readout
        @(negedge clk); host_readoutDone = 1'b1;
        @(negedge clk); host_readoutDone = 1'b0;
        check("stray_rd_done", status_done, 0);
        check("stray_rd_busy", status_busy, 0);

        // Reset in the middle of a capture wait
        @(negedge clk); host_capture = 1'b1; host_captureSkip = 1'b1;
        @(negedge clk); host_capture = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        model_reset();
        readout(1'b0, 0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op < 5) begin
                capture(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0,
                        $urandom_range(1, 30));
            end else if (op < 9) begin
                readout(1'($urandom_range(0, 1)), $urandom_range(0, 5),
                        1'($urandom_range(0, 4) == 0 && m_valid[m_latest]),
                        1'($urandom_range(0, 1)));
            end else begin
                @(negedge clk); host_readoutDone = 1'b1;
                @(negedge clk); host_readoutDone = 1'b0;
                check("rnd_stray_done", status_done, 0);
            end
            check("rnd_valid", status_validBlocks, m_valid);
            check("rnd_err", status_err, m_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
